multitone_stim_gen: RTL and testbench
=====================================

# multitone_stim_gen

Multi-tone sample source that drives the 16-bit `x_in` of the FIR filter blocks (LPF/HPF/BPF/BSF). It sums up to six direct-digital-synthesis sine tones at a fixed sample rate derived from `clk` by integer division. It emits one signed sample per sample period with a one-cycle `valid_o` strobe. Defaults reproduce the band-stop test mix: 20/40/50/60/80/100 kHz at fs = 1 MHz from a 100 MHz clock.

## Interface
- `NTONES`, 6, number of tone channels (1..8)
- `DATA_WIDTH`, 16, output sample width, signed
- `PHASE_WIDTH`, 32, phase accumulator and FCW width
- `LUT_ADDR`, 10, sine ROM address bits (1024 entries, full wave)
- `CLK_DIV`, 100, clk cycles per sample period; must be ≥ NTONES+3
- `OUT_SHIFT`, 3, arithmetic right shift applied to the tone sum
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  run enable; 0 freezes the sample divider
- `tone_mask`  in  NTONES  per-tone include bit
- `cfg_we`  in  1  frequency control word (FCW) write strobe
- `cfg_idx`  in  3  tone index for the write
- `cfg_fcw`  in  PHASE_WIDTH  FCW value
- `x_out`  out  DATA_WIDTH  signed sample, held between strobes
- `valid_o`  out  1  one-cycle pulse when `x_out` updates
- `busy`  out  1  high while the FSM is not in IDLE

## Operation
- Reset state:
  - `x_out`=0, `valid_o`=0, `busy`=0.
  - All phases are 0, and the divider count is 0.
  - FSM is in IDLE.
  - FCWs take their defaults: 85899346, 171798692, 214748365, 257698038, 343597384, 429496730 (tones 0..5). Any tone k ≥ 6 defaults to 0.
- Divider: counts 0..CLK_DIV-1 while `en`=1 and holds while `en`=0. A tick is asserted when count = CLK_DIV-1 and `en`=1.
- FSM states and transitions:
  - IDLE → FETCH on a tick.
  - FETCH lasts NTONES cycles, stepping k = 0..NTONES-1. Each cycle it registers the ROM address `phase[k][PHASE_WIDTH-1 -: LUT_ADDR]`, then updates `phase[k] <= phase[k] + fcw[k]`.
  - FETCH → DRAIN. DRAIN takes 1 cycle and lets the last ROM word arrive.
  - DRAIN → OUT. OUT takes 1 cycle, loads `x_out`, pulses `valid_o`, and returns to IDLE.
- Phase update rules:
  - Phases advance every sample regardless of `tone_mask`, so a masked tone stays phase-continuous.
  - Phases wrap modulo 2^PHASE_WIDTH.
- Accumulator:
  - Signed, DATA_WIDTH+3 bits, cleared when entering FETCH.
  - Adds ROM data for tone k in the cycle after k's address is issued, only if `tone_mask[k]`=1.
- Output arithmetic:
  - Result = acc >>> OUT_SHIFT, which floors.
  - The result is saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- ROM contents: entry a = round(32767·sin(2πa/1024)), so the range is ±32767.
- FCW writes:
  - A write with `cfg_we`=1 stores `fcw[cfg_idx]` at the next edge.
  - A write with `cfg_idx` ≥ NTONES is ignored.
  - A write that lands in the same cycle as tone k's phase update: the update uses the old FCW, and the new FCW is stored. The new value applies from the next sample.
- `tone_mask` is sampled per tone during its accumulate cycle; it is not latched per sample.
- `en` falling mid-sample: the in-flight FETCH/DRAIN/OUT sequence completes. No further ticks occur until `en` returns.
- `rst` mid-sample: the sequence is aborted, there is no `valid_o`, and all reset values are reloaded.

## Timing
- A tick at cycle t gives FETCH over t+1..t+NTONES, DRAIN at t+NTONES+1, OUT at t+NTONES+2.
- `x_out` and `valid_o` are visible after the OUT edge.
- Latency from tick to strobe is NTONES+2 cycles (8 at default).
- Strobe period is exactly CLK_DIV cycles while `en`=1.
- The first tick occurs CLK_DIV-1 cycles after reset release with `en`=1.
- ROM read latency is 1 cycle (registered output).
- The first sample after reset uses phase 0 for every tone, so it is 0.

## Structure
- Shared package `fir_pkg`:
  - FSM state encoding (IDLE, FETCH, DRAIN, OUT).
  - Default FCW constants.
  - Accumulator guard-bit constant (3).
- Sub-module `sine_rom`: 1024×16 synchronous ROM with parameters `LUT_ADDR` and `DATA_WIDTH`, initialised from the formula above.

## Test plan
- Reset with `en`=1, mask=6'b111111 → first `valid_o` at cycle CLK_DIV-1+8 after reset release, with `x_out`=0. Subsequent strobes are spaced exactly 100 cycles apart.
- mask=6'b000001, `cfg_fcw`=2^30 written to idx 0 before the first tick → `x_out` sequence 0, 4095, 0, -4096, 0, 4095…
- All six tones with FCW=2^30 and mask all ones → second sample = 6·32767 >>> 3 = 24575; fourth sample = -24576. No saturation occurs.
- OUT_SHIFT=0 build, same six-tone setup → second sample saturates to 32767, fourth to -32768.
- Write idx 6 with `cfg_fcw`=2^30 → no change to the output stream. Write idx 0 during FETCH → the new frequency is observed from the following sample, with the phase continuous.
- Drop `en` for 250 cycles mid-FETCH → the current sample still strobes, then no strobes occur. Strobes resume CLK_DIV-1+8 cycles after `en` returns, with `rst` asserted at FETCH k=3 → no strobe and `x_out`=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR test-stimulus blocks: sequencer state
// encoding, default tone frequency control words and accumulator guard bits.
// Pure declarations; no ports.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Extra accumulator bits above the sample width: headroom for 8 full-scale tones.
    localparam int ACC_GUARD = 3;

    // Default FCWs for the band-stop test mix at fs = 1 MHz, 32-bit phase:
    // round(f / fs * 2^32) for 20/40/50/60/80/100 kHz. Tones 6..7 are silent.
    function automatic logic [31:0] default_fcw(input int k);
        logic [31:0] v;
        case (k)
            0:       v = 32'd85899346;
            1:       v = 32'd171798692;
            2:       v = 32'd214748365;
            3:       v = 32'd257698038;
            4:       v = 32'd343597384;
            5:       v = 32'd429496730;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sine_rom.sv
// Full-wave sine lookup table, entry a = round(A * sin(2*pi*a/DEPTH)) with
// A = 2^(DATA_WIDTH-1)-1. Table is built at elaboration time.
// Ports: clk; addr (LUT_ADDR bits); data (signed, registered, 1-cycle latency).
module sine_rom #(
    parameter int LUT_ADDR   = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic        [LUT_ADDR-1:0]   addr,
    output logic signed [DATA_WIDTH-1:0] data
);

    localparam int  DEPTH = 1 << LUT_ADDR;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = real'((1 << (DATA_WIDTH - 1)) - 1);

    // Round half away from zero so the table is symmetric about zero.
    function automatic logic signed [DATA_WIDTH-1:0] sine_entry(input int a);
        real s;
        s = AMP * $sin(2.0 * PI * real'(a) / real'(DEPTH));
        return DATA_WIDTH'($rtoi((s >= 0.0) ? (s + 0.5) : (s - 0.5)));
    endfunction

    logic signed [DATA_WIDTH-1:0] table_q [DEPTH];

    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        assign table_q[a] = sine_entry(a);
    end

    always_ff @(posedge clk) begin
        data <= table_q[addr];
    end

endmodule

// File: rtl/multitone_stim_gen.sv
// Multi-tone DDS sample source: sums up to NTONES sine tones once every
// CLK_DIV clocks, scales by >>> OUT_SHIFT and saturates to DATA_WIDTH.
// Ports: clk/rst (sync, active-high); en gates the sample divider;
// tone_mask selects tones; cfg_we/cfg_idx/cfg_fcw write a tone's FCW;
// x_out holds the last sample, valid_o pulses for one cycle per sample;
// busy is high while a sample is being computed.
module multitone_stim_gen
    import fir_pkg::*;
#(
    parameter int NTONES      = 6,
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 32,
    parameter int LUT_ADDR    = 10,
    parameter int CLK_DIV     = 100,
    parameter int OUT_SHIFT   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic        [NTONES-1:0]      tone_mask,
    input  logic                          cfg_we,
    input  logic        [2:0]             cfg_idx,
    input  logic        [PHASE_WIDTH-1:0] cfg_fcw,
    output logic signed [DATA_WIDTH-1:0]  x_out,
    output logic                          valid_o,
    output logic                          busy
);

    localparam int ACC_W = DATA_WIDTH + ACC_GUARD;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [2:0] LAST_K = 3'(NTONES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_WIDTH - 1)));

    logic [CNT_W-1:0]              div_cnt;
    logic                          tick;
    state_t                        state, state_nxt;
    logic [2:0]                    k;
    logic [PHASE_WIDTH-1:0]        phase [NTONES];
    logic [PHASE_WIDTH-1:0]        fcw   [NTONES];
    logic [LUT_ADDR-1:0]           rom_addr;
    logic signed [DATA_WIDTH-1:0]  rom_data;
    logic                          add_vld;
    logic [2:0]                    add_idx;
    logic signed [ACC_W-1:0]       acc, acc_sum, acc_shr;
    logic signed [DATA_WIDTH-1:0]  sample_sat;

    // Sample-rate divider; frozen (not cleared) while en is low.
    assign tick = en && (div_cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    // Sequencer: one FETCH cycle per tone, then DRAIN for the last ROM word, then OUT.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (tick) state_nxt = ST_FETCH;
            ST_FETCH: if (k == LAST_K) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_OUT;
            ST_OUT:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst)                                  k <= '0;
        else if (state == ST_FETCH && k != LAST_K) k <= k + 1'b1;
        else                                      k <= '0;
    end

    // The ROM registers the address taken from the pre-update phase, so the
    // tone's word appears one cycle later while the phase has already advanced.
    assign rom_addr = phase[k][PHASE_WIDTH-1 -: LUT_ADDR];

    sine_rom #(
        .LUT_ADDR   (LUT_ADDR),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // Phases advance every sample independent of tone_mask so muted tones stay
    // phase-continuous. A concurrent FCW write only affects the next sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTONES; i++) begin
                phase[i] <= '0;
                fcw[i]   <= PHASE_WIDTH'(default_fcw(i));
            end
        end else begin
            if (state == ST_FETCH) begin
                phase[k] <= phase[k] + fcw[k];
            end
            if (cfg_we && (int'(cfg_idx) < NTONES)) begin
                fcw[cfg_idx] <= cfg_fcw;
            end
        end
    end

    // add_vld/add_idx trail the FETCH cycle by one to line up with ROM latency.
    always_comb begin
        acc_sum = acc;
        if (add_vld && tone_mask[add_idx]) begin
            acc_sum = acc + {{ACC_GUARD{rom_data[DATA_WIDTH-1]}}, rom_data};
        end
        acc_shr = acc_sum >>> OUT_SHIFT;
        if (acc_shr > SAT_MAX)      sample_sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (acc_shr < SAT_MIN) sample_sat = SAT_MIN[DATA_WIDTH-1:0];
        else                        sample_sat = acc_shr[DATA_WIDTH-1:0];
    end

    // The last tone is accumulated during DRAIN; the finished sum is taken
    // straight from acc_sum so x_out/valid_o are visible in the OUT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_vld <= 1'b0;
            add_idx <= '0;
            acc     <= '0;
            x_out   <= '0;
            valid_o <= 1'b0;
        end else begin
            add_vld <= (state == ST_FETCH);
            add_idx <= k;
            valid_o <= (state == ST_DRAIN);
            if (state == ST_IDLE && tick) acc <= '0;
            else if (add_vld)             acc <= acc_sum;
            if (state == ST_DRAIN)        x_out <= sample_sat;
        end
    end

endmodule

// File: tb/tb_multitone_stim_gen.sv
// Directed bench for multitone_stim_gen: default build plus an OUT_SHIFT=0 build.
// Latency: checks strobe timing against tick + NTONES+2 and CLK_DIV spacing.
// Backpressure: none; valid_o is a free-running strobe observed each cycle.
module tb_multitone_stim_gen;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [5:0]         tone_mask;
    logic               cfg_we;
    logic [2:0]         cfg_idx;
    logic [31:0]        cfg_fcw;
    logic signed [15:0] x_out, x_out0;
    logic               valid_o, valid0;
    logic               busy, busy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multitone_stim_gen dut (
        .clk(clk), .rst(rst), .en(en), .tone_mask(tone_mask),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_fcw(cfg_fcw),
        .x_out(x_out), .valid_o(valid_o), .busy(busy)
    );

    multitone_stim_gen #(.OUT_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .tone_mask(tone_mask),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_fcw(cfg_fcw),
        .x_out(x_out0), .valid_o(valid0), .busy(busy0)
    );

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until valid_o is seen; returns steps taken, or -1 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!valid_o && n < 400);
        if (!valid_o) n = -1;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!busy && n < 400);
        if (!busy) n = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int strobes;
        int exp_a [4];
        int exp_b [4];

        rst = 1'b1; en = 1'b1; tone_mask = 6'b111111;
        cfg_we = 1'b0; cfg_idx = 3'd0; cfg_fcw = 32'd0;

        // Reset state
        step();
        check("reset_x_out", x_out, 16'sd0);
        check("reset_valid", valid_o, 1'b0);
        check("reset_busy", busy, 1'b0);

        // First tick at cycle 99, first strobe at cycle 107, then every 100
        do_reset();
        repeat (99) step();
        check("busy_before_tick", busy, 1'b0);
        step();
        check("busy_in_fetch", busy, 1'b1);
        wait_valid(n);
        check("first_strobe_latency", 100 + n, 107);
        check("first_sample_zero", x_out, 16'sd0);
        step();
        check("valid_one_cycle", valid_o, 1'b0);
        check("busy_after_out", busy, 1'b0);
        wait_valid(n);
        check("strobe_period_1", n + 1, 100);
        wait_valid(n);
        check("strobe_period_2", n, 100);

        // Single tone at fs/4; write to nonexistent tone 6 must be ignored
        do_reset();
        tone_mask = 6'b000001;
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_fcw = 32'h4000_0000;
        step();
        cfg_idx = 3'd6; cfg_fcw = 32'h4000_0000;
        step();
        cfg_we = 1'b0;
        exp_a = '{0, 4095, 0, -4096};
        exp_b = '{0, 32767, 0, -32767};
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            check("one_tone_strobe", n > 0, 1'b1);
            check("one_tone_shift3", int'(x_out), exp_a[i]);
            check("one_tone_shift0", int'(x_out0), exp_b[i]);
        end

        // FCW write during tone 0's phase update: new FCW from next sample on
        wait_busy(n);
        check("wait_fetch_k0", n > 0, 1'b1);
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_fcw = 32'h8000_0000;
        step();
        cfg_we = 1'b0;
        exp_a = '{0, 4095, -4096, 4095};
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            check("fcw_change_sample", int'(x_out), exp_a[i]);
        end

        // en drops in FETCH k=0: sample completes, then silence, divider held
        wait_busy(n);
        check("wait_fetch_en", n > 0, 1'b1);
        en = 1'b0;
        wait_valid(n);
        check("inflight_strobe_latency", n, 7);
        check("inflight_sample", int'(x_out), -4096);
        strobes = 0;
        for (int i = 0; i < 243; i++) begin
            step();
            if (valid_o) strobes++;
        end
        check("no_strobe_while_disabled", strobes, 0);
        en = 1'b1;
        wait_valid(n);
        check("resume_latency", n, 107);
        check("resume_sample", int'(x_out), 4095);

        // Six tones at fs/4: saturation only in the OUT_SHIFT=0 build
        do_reset();
        tone_mask = 6'b111111;
        cfg_we = 1'b1; cfg_fcw = 32'h4000_0000;
        for (int i = 0; i < 6; i++) begin
            cfg_idx = 3'(i);
            step();
        end
        cfg_we = 1'b0;
        exp_a = '{0, 24575, 0, -24576};
        exp_b = '{0, 32767, 0, -32768};
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            check("six_tone_shift3", int'(x_out), exp_a[i]);
            check("six_tone_shift0_sat", int'(x_out0), exp_b[i]);
        end

        // Reset at FETCH k=3 aborts the sample
        wait_busy(n);
        check("wait_fetch_rst", n > 0, 1'b1);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("abort_x_out", x_out, 16'sd0);
        check("abort_valid", valid_o, 1'b0);
        check("abort_busy", busy, 1'b0);
        rst = 1'b0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid_o) strobes++;
        end
        check("no_strobe_after_abort", strobes, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
